// File: rtl/keypad_pkg.sv
// Shared 7-segment definitions for keypad and timer displays.
// Patterns are active-low {g,f,e,d,c,b,a}.
package keypad_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;

   // Non-BCD codes render blank so a stray value never lights a bogus glyph.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
      logic [6:0] pat;
      case (bcd)
         4'd0:    pat = SEG_0;
         4'd1:    pat = SEG_1;
         4'd2:    pat = SEG_2;
         4'd3:    pat = SEG_3;
         4'd4:    pat = SEG_4;
         4'd5:    pat = SEG_5;
         4'd6:    pat = SEG_6;
         4'd7:    pat = SEG_7;
         4'd8:    pat = SEG_8;
         4'd9:    pat = SEG_9;
         default: pat = SEG_BLANK;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder with blanking.
module bcd_to_7seg
   import keypad_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = blank ? SEG_BLANK : bcd_to_seg(bcd);
   end

endmodule

// File: rtl/keypad_digit_display.sv
// Keypad digit entry buffer with a time-multiplexed 7-segment display.
// Digits shift in calculator style; unused leading digits are blanked.
module keypad_digit_display
   import keypad_pkg::*;
#(
   parameter int NDIGITS  = 4,
   parameter int SCAN_DIV = 4
) (
   input  logic                   clk,
   input  logic                   clearn,
   input  logic [3:0]             D,
   input  logic                   loadn,
   input  logic                   enablen,
   input  logic                   clr,
   output logic [4*NDIGITS-1:0]   digits_bcd,
   output logic [3:0]             count,
   output logic                   new_digit,
   output logic                   err,
   output logic [NDIGITS-1:0]     an,
   output logic [6:0]             seg
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = $clog2(NDIGITS);

   logic             loadn_q;
   logic             strobe;
   logic [CNT_W-1:0] scan_cnt;
   logic [IDX_W-1:0] idx;
   logic [3:0]       cur_digit;
   logic             cur_blank;
   logic [6:0]       cur_seg;
   logic [NDIGITS-1:0] cur_sel;

   assign strobe = ~loadn & loadn_q;

   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         loadn_q    <= 1'b1;
         digits_bcd <= '0;
         count      <= '0;
         new_digit  <= 1'b0;
         err        <= 1'b0;
      end else begin
         loadn_q   <= loadn;
         new_digit <= 1'b0;
         err       <= 1'b0;
         // clr swallows a coincident strobe without flagging it.
         if (clr) begin
            digits_bcd <= '0;
            count      <= '0;
         end else if (strobe && !enablen) begin
            if (D <= 4'd9) begin
               digits_bcd <= {digits_bcd[4*NDIGITS-5:0], D};
               if (count < 4'(NDIGITS))
                  count <= count + 4'd1;
               new_digit <= 1'b1;
            end else begin
               err <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         idx      <= (idx == IDX_W'(NDIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   always_comb begin
      cur_digit = '0;
      cur_sel   = '1;
      for (int unsigned i = 0; i < NDIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_digit  = digits_bcd[4*i +: 4];
            cur_sel[i] = 1'b0;
         end
      end
      cur_blank = (idx != '0) && (4'(idx) >= count);
   end

   bcd_to_7seg u_dec (
      .bcd   (cur_digit),
      .blank (cur_blank),
      .seg   (cur_seg)
   );

   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         an  <= '1;
         seg <= SEG_BLANK;
      end else begin
         an  <= cur_sel;
         seg <= cur_seg;
      end
   end

endmodule

// File: tb/tb_keypad_digit_display.sv
// Bench for keypad_digit_display: cycle model of entry and scan, plus
// literal checks of the documented scenarios.
module tb_keypad_digit_display;

   localparam int N  = 4;
   localparam int SD = 4;

   logic           clk = 1'b0;
   logic           clearn;
   logic [3:0]     D;
   logic           loadn;
   logic           enablen;
   logic           clr;
   logic [4*N-1:0] digits_bcd;
   logic [3:0]     count;
   logic           new_digit;
   logic           err;
   logic [N-1:0]   an;
   logic [6:0]     seg;

   keypad_digit_display #(.NDIGITS(N), .SCAN_DIV(SD)) dut (
      .clk        (clk),
      .clearn     (clearn),
      .D          (D),
      .loadn      (loadn),
      .enablen    (enablen),
      .clr        (clr),
      .digits_bcd (digits_bcd),
      .count      (count),
      .new_digit  (new_digit),
      .err        (err),
      .an         (an),
      .seg        (seg)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int nd_seen = 0;
   int err_seen = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: digits as an integer array, scan position derived from
   // the number of clock edges since reset release.
   logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   int mbuf [N];
   int mcnt;
   int mlq;
   int k;

   initial begin : model
      logic [4*N-1:0] e_dig;
      logic [N-1:0]   e_an;
      logic [6:0]     e_seg;
      int             e_nd, e_err, sidx;
      forever begin
         @(posedge clk);
         e_nd = 0;
         e_err = 0;
         if (!clearn) begin
            for (int i = 0; i < N; i++) mbuf[i] = 0;
            mcnt = 0;
            mlq = 1;
            k = 0;
            e_an = '1;
            e_seg = 7'h7F;
         end else begin
            sidx = (k / SD) % N;
            e_an = '1;
            e_an[sidx] = 1'b0;
            e_seg = (sidx != 0 && sidx >= mcnt) ? 7'h7F : pat[mbuf[sidx]];
            if (clr) begin
               for (int i = 0; i < N; i++) mbuf[i] = 0;
               mcnt = 0;
            end else if (loadn == 1'b0 && mlq == 1 && enablen == 1'b0) begin
               if (D <= 9) begin
                  for (int i = N - 1; i > 0; i--) mbuf[i] = mbuf[i-1];
                  mbuf[0] = D;
                  mcnt = (mcnt < N) ? mcnt + 1 : N;
                  e_nd = 1;
               end else begin
                  e_err = 1;
               end
            end
            mlq = loadn;
            k++;
         end
         for (int i = 0; i < N; i++) e_dig[4*i +: 4] = 4'(mbuf[i]);
         #1;
         chk("digits_bcd", 32'(digits_bcd), 32'(e_dig));
         chk("count", 32'(count), 32'(mcnt));
         chk("new_digit", 32'(new_digit), 32'(e_nd));
         chk("err", 32'(err), 32'(e_err));
         chk("an", 32'(an), 32'(e_an));
         chk("seg", 32'(seg), 32'(e_seg));
         if (new_digit) nd_seen++;
         if (err) err_seen++;
      end
   end

   task automatic press(input logic [3:0] d, input int hold);
      @(negedge clk);
      D = d;
      loadn = 1'b0;
      repeat (hold) @(negedge clk);
      loadn = 1'b1;
      @(negedge clk);
   endtask

   initial begin : driver
      int nd0, er0, found;
      logic [N-1:0] prev_an;
      logic [N-1:0] exp_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      logic [6:0]   exp_sg [4] = '{7'h79, 7'h12, 7'h7F, 7'h7F};

      clearn = 1'b0; D = '0; loadn = 1'b1; enablen = 1'b0; clr = 1'b0;
      // 1: inputs toggle under reset
      repeat (6) begin
         @(negedge clk);
         D = 4'($urandom); loadn = 1'($urandom); enablen = 1'($urandom); clr = 1'($urandom);
      end
      @(negedge clk);
      chk("rst_digits", 32'(digits_bcd), 32'h0);
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'h7F);
      D = '0; loadn = 1'b1; enablen = 1'b0; clr = 1'b0; clearn = 1'b1;

      // 2: long holds give one capture each
      nd0 = nd_seen;
      press(4'd5, 5);
      chk("t2_first", 32'(digits_bcd), 32'h0005);
      press(4'd1, 5);
      chk("t2_second", 32'(digits_bcd), 32'h0051);
      chk("t2_count", 32'(count), 32'd2);
      chk("t2_pulses", 32'(nd_seen - nd0), 32'd2);

      // 5: scan sequence for 0051
      found = 0;
      prev_an = an;
      for (int c = 0; c < 4 * N * SD + 8 && found == 0; c++) begin
         @(posedge clk); #2;
         if (an == 4'b1110 && prev_an == 4'b0111) found = 1;
         prev_an = an;
      end
      chk("t5_scan_sync", 32'(found), 32'd1);
      if (found == 1) begin
         for (int c = 0; c < 16; c++) begin
            if (c > 0) begin @(posedge clk); #2; end
            chk("t5_an", 32'(an), 32'(exp_an[c/4]));
            chk("t5_seg", 32'(seg), 32'(exp_sg[c/4]));
         end
      end

      // 3: overflow discards the most significant digit
      nd0 = nd_seen;
      for (int i = 1; i <= 5; i++) press(4'(i), 2);
      chk("t3_digits", 32'(digits_bcd), 32'h2345);
      chk("t3_count", 32'(count), 32'd4);
      chk("t3_pulses", 32'(nd_seen - nd0), 32'd5);

      // 4: disabled entry and invalid digit
      nd0 = nd_seen; er0 = err_seen;
      enablen = 1'b1;
      press(4'd7, 3);
      enablen = 1'b0;
      press(4'hB, 3);
      chk("t4_digits", 32'(digits_bcd), 32'h2345);
      chk("t4_pulses", 32'(nd_seen - nd0), 32'd0);
      chk("t4_err", 32'(err_seen - er0), 32'd1);

      // enable falling while the key is already held must not capture
      @(negedge clk); enablen = 1'b1; D = 4'd6; loadn = 1'b0;
      @(negedge clk); enablen = 1'b0;
      repeat (3) @(negedge clk);
      loadn = 1'b1;
      @(negedge clk);
      chk("late_enable", 32'(digits_bcd), 32'h2345);

      // 6: clr on the strobe cycle
      nd0 = nd_seen;
      @(negedge clk); D = 4'd3; loadn = 1'b0; clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      repeat (3) @(negedge clk);
      loadn = 1'b1;
      @(negedge clk);
      chk("t6_digits", 32'(digits_bcd), 32'h0);
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_pulses", 32'(nd_seen - nd0), 32'd0);

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) loadn = ~loadn;
         D = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         enablen = ($urandom_range(0, 7) == 0);
         clr = ($urandom_range(0, 40) == 0);
      end
      clr = 1'b0; enablen = 1'b0;

      // async reset mid-scan and mid-press; held key captured on release
      press(4'd8, 2);
      @(negedge clk); D = 4'd9; loadn = 1'b0;
      #2 clearn = 1'b0;
      #1;
      chk("t6_async_an", 32'(an), 32'hF);
      chk("t6_async_seg", 32'(seg), 32'h7F);
      chk("t6_async_dig", 32'(digits_bcd), 32'h0);
      repeat (2) @(negedge clk);
      clearn = 1'b1;
      @(negedge clk);
      chk("held_through_reset", 32'(digits_bcd), 32'h0009);
      loadn = 1'b1;
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
